i2s_tdm_tx: RTL
===============

// Module: i2s_tdm_tx
// PURPOSE
//  Parametrised audio serial transmitter with an integrated sample FIFO.
//  Generalises the stereo I2S output path to N channels, configurable sample/slot widths and FIFO depth.
//  Supports two framing modes: I2S (50% duty wclk) and TDM (one-bclk frame-sync pulse).
//  Sits between the AXI-side sample writer and the codec pins, with I2S bclk derived from clk by an internal divider.
// PARAMETERS
//  SAMPLE_W   24  valid bits per channel sample (1..SLOT_W)
//  SLOT_W     32  bclk periods per channel slot
//  NUM_CH      2  channels per frame; must be even for I2S mode
//  FIFO_DEPTH  8  FIFO depth in frames; power of 2, >=2
//  BCLK_DIV    4  clk cycles per bclk half-period (>=1)
// PORTS
//  clk           in   1                         sole clock; all logic on rising edge
//  reset_n       in   1                         asynchronous, active-low reset
//  enable        in   1                         run request
//  tdm_mode      in   1                         0 = I2S framing, 1 = TDM framing
//  data_in       in   NUM_CH*SAMPLE_W           one frame; ch0 in the MSBs
//  data_wr       in   1                         push data_in into the FIFO
//  fifo_full     out  1                         FIFO holds FIFO_DEPTH frames
//  fifo_level    out  $clog2(FIFO_DEPTH)+1      frames stored
//  underrun      out  1                         sticky: frame started with FIFO empty
//  overflow      out  1                         sticky: write dropped while full
//  flags_clr     in   1                         clears underrun and overflow
//  busy          out  1                         serializer running
//  i2s_bclk      out  1                         bit clock
//  i2s_wclk      out  1                         word clock / frame sync
//  i2s_data      out  1                         serial data, MSB first
// BEHAVIOUR
//  Reset (reset_n=0, asynchronous): every output is 0, the FIFO is empty, all counters are 0 and the FSM is in IDLE.
//  FIFO writes
//   - A write is accepted when data_wr=1 and fifo_full=0; fifo_level updates on the next cycle.
//   - fullness is judged before a same-cycle pop, so a write while full is always dropped and sets overflow.
//   - A pop and a write in the same cycle when not full leave the level unchanged.
//  Bit clock
//   - div_cnt counts 0..BCLK_DIV-1 while busy; i2s_bclk toggles when div_cnt wraps.
//   - The 1->0 transition is the "fall event"; i2s_data and i2s_wclk change only on fall events.
//  Frame
//   - bit_cnt counts 0..NUM_CH*SLOT_W-1, advancing on each fall event.
//   - Slot c carries channel c: SAMPLE_W bits MSB first, then SLOT_W-SAMPLE_W zero bits.
//   - i2s_data is the frame stream delayed by one bclk. At bit_cnt=0 it carries the last bit of the previous frame, or 0 after idle.
//  Word clock
//   - I2S mode: i2s_wclk=0 for bit_cnt < NUM_CH*SLOT_W/2, else 1.
//   - TDM mode: i2s_wclk=1 only for bit_cnt=0.
//  Frame load
//   - At each frame start (bit_cnt wraps to 0, or IDLE->RUN), pop one frame into the shift register.
//   - If the FIFO is empty at frame start: load zeros and set underrun.
//  Flags: underrun and overflow are sticky; flags_clr clears them; a set in the same cycle as flags_clr wins.
//  tdm_mode is sampled only at frame start.
//  FSM
//   - IDLE: busy=0, bclk/wclk/data held at 0. enable=1 -> RUN on the next cycle with div_cnt=0, bit_cnt=0; the frame loads at entry.
//   - RUN: busy=1. enable=0 -> DRAIN; the current frame is never truncated.
//   - DRAIN: continues until the fall event ending bit_cnt=NUM_CH*SLOT_W-1, then the delayed last bit is driven for one bclk -> IDLE.
//     enable=1 during DRAIN -> back to RUN with no gap.
//  Reset mid-frame aborts immediately: outputs go to 0 and FIFO contents are discarded.
// TESTING (SAMPLE_W=24, SLOT_W=32, NUM_CH=2, FIFO_DEPTH=8, BCLK_DIV=2 unless noted)
//  1. Assert reset_n=0 mid-frame -> all outputs 0 asynchronously, fifo_level=0, no bclk edges until enable is re-raised.
//  2. Write {0xABCDEF,0x123456}, enable, I2S mode -> bclk period 4 clk; wclk low for 32 bclk then high for 32.
//     data shows 0xABCDEF then 8 zeros, then 0x123456 then 8 zeros, each delayed 1 bclk.
//  3. Enable with FIFO empty -> data stays 0, underrun=1 at the first frame start.
//     Pulse flags_clr -> underrun=0 next cycle; it sets again at the next empty frame start.
//  4. Write 9 frames with enable=0 -> fifo_full=1, fifo_level=8, overflow=1; 9th frame is absent in the output.
//  5. NUM_CH=4, tdm_mode=1, two frames queued -> wclk is a 1-bclk pulse every 128 bclks; slots 0..3 carry the queued samples in order.
//  6. Drop enable at bit_cnt=10 -> frame completes through bit 63 plus the delayed bit; busy falls, bclk is held at 0, the next frame stays in the FIFO.

Source files
------------

// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: FIFO-buffered N-channel serial audio transmitter with I2S (50% wclk) or TDM (1-bclk sync) framing.
// Latency: a queued frame is loaded at the next frame start (IDLE->RUN entry or bit_cnt wrap); i2s_data lags the frame by one bclk.
// Backpressure: none upstream; writes while fifo_full are dropped (overflow), an empty FIFO at frame start sends zeros (underrun).
//
// Ports:
//   clk, reset_n           sole clock (rising edge), asynchronous active-low reset
//   enable, tdm_mode       run request; framing select, sampled at each frame start
//   data_in, data_wr       one frame (ch0 in the MSBs) and its push strobe
//   fifo_full, fifo_level  FIFO status (level in frames)
//   underrun, overflow     sticky error flags, cleared by flags_clr (a same-cycle set wins)
//   busy                   serializer active (RUN, DRAIN or final delayed bit)
//   i2s_bclk/wclk/data     codec pins; wclk and data change only on bclk falling edges
module i2s_tdm_tx #(
  parameter int SAMPLE_W   = 24,
  parameter int SLOT_W     = 32,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int BCLK_DIV   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          tdm_mode,
  input  logic [NUM_CH*SAMPLE_W-1:0]    data_in,
  input  logic                          data_wr,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          overflow,
  input  logic                          flags_clr,
  output logic                          busy,
  output logic                          i2s_bclk,
  output logic                          i2s_wclk,
  output logic                          i2s_data
);

  localparam int IN_W    = NUM_CH * SAMPLE_W;
  localparam int FRAME_W = NUM_CH * SLOT_W;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = $clog2(FIFO_DEPTH) + 1;
  localparam int BW      = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int DW      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
  localparam logic [BW-1:0] BIT_HALF = BW'(FRAME_W / 2);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  // TAIL drives the delayed last bit of a drained frame for one bclk
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, TAIL} state_t;

  // ---------------- sample FIFO ----------------
  logic [IN_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic            fifo_empty, wr_acc, pop;

  // ---------------- serializer ----------------
  state_t             state;
  logic [DW-1:0]      div_cnt;
  logic [BW-1:0]      bit_cnt, next_bit;
  logic [FRAME_W-1:0] shreg, load_frame;
  logic               tdm_q;
  logic               div_wrap, fall, bit_last, continuing, frame_start;

  // Expand a packed frame into slot layout: each sample MSB-aligned in its slot, zero padded.
  function automatic logic [FRAME_W-1:0] fmt(input logic [IN_W-1:0] s);
    logic [FRAME_W-1:0] f, t;
    f = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      t = '0;
      t[SAMPLE_W-1:0] = s[(NUM_CH-1-c)*SAMPLE_W +: SAMPLE_W];
      f = f | (t << ((NUM_CH-1-c)*SLOT_W + (SLOT_W-SAMPLE_W)));
    end
    return f;
  endfunction

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_FULL);
  assign fifo_level = level;
  assign wr_acc     = data_wr & ~fifo_full;
  assign pop        = frame_start & ~fifo_empty;
  assign load_frame = fmt(fifo_empty ? '0 : mem[rd_ptr]);

  assign div_wrap   = (div_cnt == DIV_LAST);
  assign fall       = div_wrap & i2s_bclk;
  assign bit_last   = (bit_cnt == BIT_LAST);
  assign next_bit   = bit_cnt + 1'b1;
  // DRAIN with enable re-raised behaves as RUN so the next frame follows without a gap
  assign continuing = (state == RUN) | ((state == DRAIN) & enable);
  assign frame_start = ((state == IDLE) & enable) | (fall & bit_last & continuing);

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (frame_start & fifo_empty) underrun <= 1'b1;
      else if (flags_clr)           underrun <= 1'b0;
      if (data_wr & fifo_full)      overflow <= 1'b1;
      else if (flags_clr)           overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      i2s_bclk <= 1'b0;
      i2s_wclk <= 1'b0;
      i2s_data <= 1'b0;
      tdm_q    <= 1'b0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            // entry acts as the first frame start: bit 0 is presented now, bclk rises BCLK_DIV later
            state    <= RUN;
            busy     <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            i2s_wclk <= tdm_mode;
            i2s_data <= 1'b0;
            tdm_q    <= tdm_mode;
            shreg    <= load_frame;
          end
        end
        default: begin
          if (div_wrap) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          if ((state == RUN) && !enable)      state <= DRAIN;
          else if ((state == DRAIN) && enable) state <= RUN;

          if (fall) begin
            if (state == TAIL) begin
              state    <= IDLE;
              busy     <= 1'b0;
              div_cnt  <= '0;
              i2s_wclk <= 1'b0;
              i2s_data <= 1'b0;
            end else begin
              // shreg MSB is the bit of the slot just finished: one-bclk data delay
              i2s_data <= shreg[FRAME_W-1];
              if (bit_last) begin
                bit_cnt <= '0;
                if (continuing) begin
                  shreg    <= load_frame;
                  tdm_q    <= tdm_mode;
                  i2s_wclk <= tdm_mode;
                end else begin
                  // no new frame follows, so no sync pulse and I2S wclk back to 0
                  state    <= TAIL;
                  i2s_wclk <= 1'b0;
                end
              end else begin
                bit_cnt  <= next_bit;
                shreg    <= shreg << 1;
                i2s_wclk <= ~tdm_q & (next_bit >= BIT_HALF);
              end
            end
          end
        end
      endcase
    end
  end

endmodule
